// File: rtl/lfsr_cipher_pkg.sv
// Shared types and constants for the LFSR cipher engine: FSM states,
// the pad character used for preamble matching, and the candidate
// tap-pattern table walked during a decrypt search.
package lfsr_cipher_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED   = 3'd1,
        TRY    = 3'd2,
        DECODE = 3'd3,
        ENC    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [7:0] PAD_CHAR  = 8'h20;
    localparam int         NUM_TABLE = 9;

    // Candidate tap patterns in search order; indices past the table give 0.
    function automatic logic [6:0] table_ptrn(input logic [3:0] k);
        case (k)
            4'd0:    return 7'h60;
            4'd1:    return 7'h48;
            4'd2:    return 7'h78;
            4'd3:    return 7'h72;
            4'd4:    return 7'h6A;
            4'd5:    return 7'h69;
            4'd6:    return 7'h5C;
            4'd7:    return 7'h7E;
            4'd8:    return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_cipher_engine_step.sv
// Combinational single-step LFSR: shift left, feed back the parity of the
// tapped bits into bit 0.
module lfsr_step #(
    parameter int LFSR_W = 7
) (
    input  logic [LFSR_W-1:0] state,
    input  logic [LFSR_W-1:0] ptrn,
    output logic [LFSR_W-1:0] state_next
);

    assign state_next = {state[LFSR_W-2:0], ^(state & ptrn)};

endmodule

// File: rtl/lfsr_cipher_engine.sv
// LFSR stream cipher engine. Encrypt XORs each source byte with the LFSR
// state and adds even parity in bit 7. Decrypt recovers the seed from the
// first byte, searches the pattern table for one whose keystream turns the
// preamble into pad characters, then decodes the whole message.
//
// Memory port: one byte is processed per cycle, so in ENC/DECODE the engine
// presents the destination address (DST_BASE+i) with MemWe high, and the
// memory returns the paired source byte (SRC_BASE+i) on MemRdData in the same
// cycle. In SEED/TRY only reads occur and MemAddr is the source address.
module lfsr_cipher_engine
    import lfsr_cipher_pkg::*;
#(
    parameter int LFSR_W    = 7,
    parameter int NUM_PTRN  = 9,
    parameter int MSG_LEN   = 64,
    parameter int CHECK_LEN = 8,
    parameter int SRC_BASE  = 64,
    parameter int DST_BASE  = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [LFSR_W-1:0] PtrnIn,
    input  logic [LFSR_W-1:0] SeedIn,
    output logic [7:0]        MemAddr,
    input  logic [7:0]        MemRdData,
    output logic [7:0]        MemWrData,
    output logic              MemWe,
    output logic              Ack,
    output logic [3:0]        PtrnIdx,
    output logic              NoMatch,
    output logic              ParityErr
);

    localparam logic [7:0] SRC_A     = 8'(SRC_BASE);
    localparam logic [7:0] DST_A     = 8'(DST_BASE);
    localparam logic [7:0] LAST_BYTE = 8'(MSG_LEN - 1);
    localparam logic [7:0] LAST_CHK  = 8'(CHECK_LEN - 1);
    localparam logic [3:0] LAST_K    = 4'(NUM_PTRN - 1);

    state_t            state, state_n;
    logic              start_q;
    logic [7:0]        idx;
    logic [3:0]        k;
    logic [3:0]        ptrn_idx_q;
    logic              no_match_q, par_err_q;

    logic [LFSR_W-1:0] st, seed_r, ptrn_r;
    logic [LFSR_W-1:0] step_ptrn, step_out, seed_w, tbl_ptrn;
    logic [6:0]        tbl7, seed7, st_ext, step_ext, xor_lo;
    logic              launch, try_ok, par_bad;

    logic [7:0]        mem_addr, mem_wr;
    logic              mem_we, ack;

    assign tbl7      = table_ptrn(k);
    assign tbl_ptrn  = tbl7[LFSR_W-1:0];
    assign seed7     = MemRdData[6:0] ^ PAD_CHAR[6:0];
    assign seed_w    = seed7[LFSR_W-1:0];
    assign step_ptrn = (state == TRY) ? tbl_ptrn : ptrn_r;
    assign st_ext    = 7'(st);
    assign step_ext  = 7'(step_out);
    assign xor_lo    = MemRdData[6:0] ^ st_ext;
    assign try_ok    = ((MemRdData[6:0] ^ step_ext) == PAD_CHAR[6:0]);
    assign par_bad   = MemRdData[7] != (^MemRdData[6:0]);
    assign launch    = start_q & ~Start;

    lfsr_step #(.LFSR_W(LFSR_W)) u_step (
        .state      (st),
        .ptrn       (step_ptrn),
        .state_next (step_out)
    );

    // State register plus control counters and sticky status flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            idx        <= '0;
            k          <= '0;
            ptrn_idx_q <= '0;
            no_match_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= Start;
            case (state)
                IDLE: begin
                    if (launch) begin
                        idx        <= '0;
                        k          <= '0;
                        ptrn_idx_q <= '0;
                        no_match_q <= 1'b0;
                        par_err_q  <= 1'b0;
                    end
                end
                SEED: begin
                    idx <= 8'd1;
                    k   <= '0;
                    if (seed_w == '0) no_match_q <= 1'b1;
                end
                TRY: begin
                    if (try_ok) begin
                        if (idx == LAST_CHK) begin
                            ptrn_idx_q <= k;
                            idx        <= '0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end else begin
                        idx <= 8'd1;
                        if (k == LAST_K) no_match_q <= 1'b1;
                        else             k <= k + 4'd1;
                    end
                end
                ENC: idx <= idx + 8'd1;
                DECODE: begin
                    idx <= idx + 8'd1;
                    if (par_bad) par_err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // LFSR state, recovered seed and active pattern; no reset needed.
    always_ff @(posedge Clk) begin
        case (state)
            IDLE: begin
                st     <= SeedIn;
                ptrn_r <= PtrnIn;
            end
            SEED: begin
                st     <= seed_w;
                seed_r <= seed_w;
            end
            TRY: begin
                if (try_ok && idx != LAST_CHK) st <= step_out;
                else                           st <= seed_r;
                if (try_ok && idx == LAST_CHK) ptrn_r <= tbl_ptrn;
            end
            ENC, DECODE: st <= step_out;
            default: ;
        endcase
    end

    // Next-state logic and memory/handshake outputs.
    always_comb begin
        state_n  = state;
        mem_addr = '0;
        mem_wr   = '0;
        mem_we   = 1'b0;
        ack      = 1'b0;
        case (state)
            IDLE: if (launch) state_n = Mode ? SEED : ENC;
            SEED: begin
                mem_addr = SRC_A;
                state_n  = (seed_w == '0) ? DONE : TRY;
            end
            TRY: begin
                mem_addr = SRC_A + idx;
                if (try_ok) begin
                    if (idx == LAST_CHK) state_n = DECODE;
                end else if (k == LAST_K) begin
                    state_n = DONE;
                end
            end
            ENC: begin
                mem_addr = DST_A + idx;
                mem_we   = 1'b1;
                mem_wr   = {^xor_lo, xor_lo};
                if (idx == LAST_BYTE) state_n = DONE;
            end
            DECODE: begin
                mem_addr = DST_A + idx;
                mem_we   = 1'b1;
                mem_wr   = {1'b0, xor_lo};
                if (idx == LAST_BYTE) state_n = DONE;
            end
            DONE: begin
                ack = 1'b1;
                if (Start) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign MemAddr   = Reset ? 8'h00 : mem_addr;
    assign MemWrData = Reset ? 8'h00 : mem_wr;
    assign MemWe     = ~Reset & mem_we;
    assign Ack       = ~Reset & ack;
    assign PtrnIdx   = Reset ? 4'h0 : ptrn_idx_q;
    assign NoMatch   = ~Reset & no_match_q;
    assign ParityErr = ~Reset & par_err_q;

endmodule

// File: doc/lfsr_cipher_engine.md
LFSR_CIPHER_ENGINE -- requirements
Module: lfsr_cipher_engine

Interface
REQ-001 Parameter LFSR_W, default 7: LFSR state width, legal range 2..7.
REQ-002 Parameter NUM_PTRN, default 9: number of candidate tap patterns searched in decrypt mode.
REQ-003 Parameter MSG_LEN, default 64: number of bytes processed per run.
REQ-004 Parameter CHECK_LEN, default 8: preamble bytes matched during pattern search, legal range 2..10.
REQ-005 Parameter SRC_BASE, default 64, and DST_BASE, default 0: byte base addresses for source and destination.
REQ-006 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 Start  in  1  high holds the engine idle; the run launches on the first cycle Start is sampled low after being high.
REQ-009 Mode  in  1  0 selects encrypt, 1 selects decrypt; sampled at launch.
REQ-010 PtrnIn  in  LFSR_W  tap pattern used in encrypt mode; sampled at launch.
REQ-011 SeedIn  in  LFSR_W  nonzero LFSR start state used in encrypt mode; sampled at launch.
REQ-012 MemAddr  out  8  data-memory byte address.
REQ-013 MemRdData  in  8  data-memory read data, valid combinationally in the same cycle as MemAddr.
REQ-014 MemWrData  out  8  write data.
REQ-015 MemWe  out  1  write enable.
REQ-016 Ack  out  1  run complete.
REQ-017 PtrnIdx  out  4  index of the matched pattern after a decrypt run.
REQ-018 NoMatch  out  1  decrypt search failed.
REQ-019 ParityErr  out  1  sticky flag; at least one decrypted byte failed its parity check.

Function
REQ-020 The LFSR shall advance one step per processed byte: next = {state[LFSR_W-2:0], ^(state & ptrn)}.
REQ-021 Encrypt byte i shall read SRC_BASE+i and write DST_BASE+i with value c.
  - c[6:0] = d[6:0] ^ zero-extended state.
  - c[7] = ^c[6:0].
REQ-022 Encrypt shall process one byte per cycle for MSG_LEN cycles, then assert Ack.
REQ-023 Decrypt SEED state: read SRC_BASE.
  - seed = (MemRdData[6:0] ^ 7'h20)[LFSR_W-1:0].
  - If seed == 0, set NoMatch and go to DONE.
REQ-024 Decrypt TRY state: for candidate k = 0..NUM_PTRN-1, starting from seed, step the LFSR and compare bytes 1..CHECK_LEN-1 (one byte per cycle) against pad 0x20 on bits [6:0].
  - On the first mismatch, abort and move to k+1.
  - The first k with a full match is selected.
REQ-025 If no candidate matches, NoMatch shall be set, no memory writes shall occur, and the engine goes to DONE.
REQ-026 Decrypt DECODE state: for i = 0..MSG_LEN-1, restart from seed with the selected pattern.
  - Write DST_BASE+i = {1'b0, c[6:0] ^ state}.
  - Set ParityErr if c[7] != ^c[6:0].
REQ-027 FSM states: IDLE, SEED, TRY, DECODE, ENC, DONE.
  - IDLE -> ENC or SEED at launch, selected by Mode.
  - ENC, DECODE -> DONE after byte MSG_LEN-1.
  - DONE -> IDLE when Start is sampled high.
REQ-028 Ack shall be high only in DONE, and shall stay high until Start rises.
REQ-029 MemWe shall be high only in ENC and DECODE.
REQ-030 Addresses shall be computed modulo 256 (wrap-around).
REQ-031 PtrnIdx, NoMatch and ParityErr shall be cleared at launch and held stable in DONE.

Reset
REQ-032 Reset shall force IDLE on the same edge, including mid-run, aborting any run in progress.
REQ-033 Under reset, all outputs shall be 0: Ack, MemWe, MemAddr, MemWrData, PtrnIdx, NoMatch and ParityErr.
REQ-034 Reset shall take priority over Start.

Structure
REQ-035 Package lfsr_cipher_pkg shall hold the state enum, PAD_CHAR = 8'h20, and the candidate pattern table.
  - Table: 7'h60, 48, 78, 72, 6A, 69, 5C, 7E, 7B.
REQ-036 One sub-module, lfsr_step, shall provide the combinational next-state function for LFSR_W.

Verification
REQ-037 Encrypt a 0x20 pad with PtrnIn=7'h60, SeedIn=7'h01 -> DST[0]=0x21 and DST[1]=0x22; Ack is high 65 cycles after launch.
REQ-038 Decrypt a 64-byte message produced with pattern 7'h6A, seed 7'h2B and a 12-byte pad -> PtrnIdx=4, DST[0..63] equals the plaintext, ParityErr=0.
REQ-039 Decrypt with the preamble byte 3 corrupted to 0x00 -> NoMatch=1, no MemWe pulses, Ack high.
REQ-040 Decrypt with bit 7 of byte 20 flipped -> ParityErr=1, and DST[20] is still decoded from bits [6:0].
REQ-041 Assert Reset at decode byte 10 -> state is IDLE and MemWe is 0 on the next edge; a new launch completes correctly.
REQ-042 Hold Start high throughout -> Ack stays 0 and no memory writes occur.
